// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - CPU bus memory responder with wait states, ROM window, preload port and access counters
module bus_mem_responder #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                MEM_AW      = 12,
    parameter int                WAIT_CYCLES = 0,
    parameter int                ROM_EN      = 1,
    parameter logic [ADDR_W-1:0] ROM_BASE    = 16'hF000,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              readNotWrite,
    input  logic [DATA_W-1:0] dataBusOutput,
    input  logic              dataBusEnable,
    output logic [DATA_W-1:0] dataBusInput,
    output logic              ready,
    input  logic              loadEnable,
    input  logic [ADDR_W-1:0] loadAddress,
    input  logic [DATA_W-1:0] loadData,
    output logic [CNT_W-1:0]  readCount,
    output logic [CNT_W-1:0]  writeCount,
    output logic [CNT_W-1:0]  blockedWrites
);
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SERVE = 2'd3;
    localparam int         KEY_W    = ADDR_W + 1;

    logic [DATA_W-1:0] mem [0:(2**MEM_AW)-1];

    logic [MEM_AW-1:0] cpuIndex;
    logic [MEM_AW-1:0] loadIndex;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  lastKey;
    logic              keyValid;
    logic [7:0]        waitCnt;
    logic              newAcc;
    logic              romHit;
    logic              cpuWrite;
    logic [1:0]        state;
    logic              unusedLoadBits;

    // The array is mirrored: only the low MEM_AW address bits select a location.
    assign cpuIndex       = address[MEM_AW-1:0];
    assign loadIndex      = loadAddress[MEM_AW-1:0];
    assign unusedLoadBits = ^loadAddress;
    assign key            = {address, readNotWrite};
    assign newAcc         = !keyValid || (key != lastKey);
    assign romHit         = (ROM_EN != 0) && (address >= ROM_BASE);
    assign ready          = !rst && !loadEnable && (WAIT_CYCLES == 0 || (!newAcc && waitCnt == 8'd0));
    assign cpuWrite       = (state == ST_SERVE) && !readNotWrite && dataBusEnable;
    assign dataBusInput   = rst ? '0 : mem[cpuIndex];

    always_comb begin
        state = ST_WAIT;
        if (rst)             state = ST_RESET;
        else if (loadEnable) state = ST_LOAD;
        else if (ready)      state = ST_SERVE;
    end

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        case (state)
            ST_RESET: begin
                keyValid      <= 1'b0;
                lastKey       <= '0;
                waitCnt       <= 8'd0;
                readCount     <= '0;
                writeCount    <= '0;
                blockedWrites <= '0;
            end
            ST_LOAD: begin
                keyValid <= 1'b0;
            end
            ST_WAIT: begin
                if (newAcc) begin
                    lastKey  <= key;
                    keyValid <= 1'b1;
                    waitCnt  <= 8'(WAIT_CYCLES - 1);
                end else if (waitCnt != 8'd0) begin
                    waitCnt <= waitCnt - 8'd1;
                end
            end
            default: begin
                // Zero-wait builds reach here on a new key, so it is tracked here too.
                if (newAcc) begin
                    lastKey  <= key;
                    keyValid <= 1'b1;
                end
                if (readNotWrite) begin
                    readCount <= satInc(readCount);
                end else if (dataBusEnable) begin
                    if (romHit) blockedWrites <= satInc(blockedWrites);
                    else        writeCount    <= satInc(writeCount);
                end
            end
        endcase
    end

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            mem[loadIndex] <= loadData;
        end else if (cpuWrite && !romHit) begin
            mem[cpuIndex] <= dataBusOutput;
        end
    end
endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Parametrised, synthesisable bus-side memory responder for the 8227 CPU core. It replaces ad-hoc behavioural memory arrays in benches and FPGA bring-up builds. It serves CPU reads and writes from an internal array, inserts a programmable number of wait states via `ready`, and write-protects a ROM window above a base address. It also provides a preload port and saturating access counters. It sits between `top8227` and the rest of the system, with `address = {AddressBusHigh, AddressBusLow}`.

## Interface
- `ADDR_W`, 16, CPU address width.
- `DATA_W`, 8, data width.
- `MEM_AW`, 12, array index width. Depth is 2^MEM_AW, and the array is mirrored across the address space.
- `WAIT_CYCLES`, 0, `ready`-low cycles inserted on each new access (0..255).
- `ROM_EN`, 1, enables write protection.
- `ROM_BASE`, 16'hF000, first protected address (compared against the full `address`).
- `CNT_W`, 16, counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `address`  in  ADDR_W  CPU address.
- `readNotWrite`  in  1  1 = read, 0 = write.
- `dataBusOutput`  in  DATA_W  CPU write data.
- `dataBusEnable`  in  1  write qualifier. A CPU write happens only when this is 1.
- `dataBusInput`  out  DATA_W  read data to the CPU.
- `ready`  out  1  access completes on a rising edge where `ready`=1.
- `loadEnable`  in  1  preload write request.
- `loadAddress`  in  ADDR_W  preload address.
- `loadData`  in  DATA_W  preload data.
- `readCount`  out  CNT_W  completed reads.
- `writeCount`  out  CNT_W  committed CPU writes.
- `blockedWrites`  out  CNT_W  CPU writes rejected by protection.

## Operation
- **Index:** `index = address[MEM_AW-1:0]`, likewise for `loadAddress`. The array is not cleared by `rst`, so contents survive reset.
- **Read data:** `dataBusInput` is a combinational read of `mem[index]`. It is forced to 0 while `rst`=1.
- **Access key:** `{address, readNotWrite}`. State registers are `lastKey`, `keyValid` and `waitCnt` (8 bit).
- **New access:** `newAcc = !keyValid || key != lastKey`.
- **Ready:** `ready = !rst && !loadEnable && (WAIT_CYCLES==0 || (!newAcc && waitCnt==0))`.
- **States:**
  - RESET: `rst`=1.
  - LOAD: `loadEnable`=1.
  - WAIT: `waitCnt`≠0 or `newAcc` with WAIT_CYCLES>0.
  - SERVE: `ready`=1.
- **Priority:** `rst` > `loadEnable` > CPU.
- **RESET** (on the edge): `keyValid`←0, `lastKey`←0, `waitCnt`←0, all counters←0.
- **LOAD** (on the edge):
  - `mem[loadIndex]`←`loadData`, ignoring protection.
  - `keyValid`←0.
  - No CPU write and no counter change.
- **WAIT:**
  - If `newAcc`: `lastKey`←key, `keyValid`←1, `waitCnt`←WAIT_CYCLES−1.
  - Otherwise, if `waitCnt`≠0, decrement it.
  - No memory or counter effect.
- **SERVE** (edge with `ready`=1). When WAIT_CYCLES=0, `lastKey`/`keyValid` are still updated on `newAcc`.
  - Read: `readCount`+1.
  - Write with `dataBusEnable`=1:
    - If `ROM_EN && address >= ROM_BASE`: no write, `blockedWrites`+1.
    - Otherwise: `mem[index]`←`dataBusOutput`, `writeCount`+1.
  - Write with `dataBusEnable`=0: no effect.
- **Repeated accesses:** a key held across multiple ready cycles completes once per cycle. This matches the CPU's one-access-per-cycle behaviour.
- **Counters:** saturate at all ones and never wrap.

## Timing
- **Reset values** (during and immediately after `rst`): `ready`=0 during `rst`, `dataBusInput`=0 during `rst`, counters=0, `keyValid`=0.
- **Wait states:** with WAIT_CYCLES=N≥1 and a new key first presented in cycle t:
  - `ready`=0 in cycles t … t+N−1.
  - `ready`=1 in cycle t+N, and the access completes at the end of that cycle.
- **Zero wait:** with N=0, `ready`=1 every non-reset, non-load cycle.
- **Read latency:** combinational, 0 cycles. Data written at edge e is readable in the cycle after e.
- **Key change mid-wait:** restarts the count with the full N cycles.
- **Load release:** after `loadEnable` falls, the next CPU access incurs the full N wait cycles.
- **Reset mid-wait:** the wait is aborted. The first access after `rst` falls incurs the full N cycles.
- **Load and CPU write to the same index in one cycle:** the load wins and the CPU write is dropped.

## Test plan
- **Preload and read:** N=0; load 0xFFFC←0xDD and 0xFFFD←0xCC; CPU reads 0xFFFC then 0xFFFD -> `dataBusInput` 0xDD then 0xCC, `ready`=1 throughout, `readCount`=2.
- **Wait states:** N=3; read 0x0099 (holding 0x73), then switch to 0x0098 -> `ready` low exactly 3 cycles for each address, high on the 4th, data 0x73; `readCount` increments only on ready-high edges.
- **Writes and protection:** write 0x73 to 0x0050 with `dataBusEnable`=1 -> readback 0x73, `writeCount`=1. Write 0x55 to 0xF010 -> contents unchanged, `blockedWrites`=1. Write with `dataBusEnable`=0 -> no change, no count.
- **Mirroring:** MEM_AW=12; write 0xA5 to 0x0123; read 0x1123 -> 0xA5.
- **Load during access:** N=2; assert `loadEnable` mid-wait and load 0xF000←0x11 -> `ready`=0 while loading, ROM location becomes 0x11. After release, the next access has 2 wait cycles.
- **Reset and saturation:**
  - Reset mid-wait: `rst` asserted with `waitCnt`=1 -> counters 0, `ready`=0, preloaded memory intact, full wait on the first post-reset access.
  - Saturation: CNT_W=2; 5 reads -> `readCount`=3.
